// File: rtl/seg7_scan_decoder.sv
// Recovers decimal digit codes from a multiplexed, one-hot-scanned 7-segment bus.
// Completed frames are presented on a valid/ready handshake and held until they are accepted.

// Working storage for one digit position: the latest decoded code/err plus a captured flag.
module seg7_scan_slot (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic       clr,
  input  logic [3:0] code_in,
  input  logic       err_in,
  output logic [3:0] code_nxt,
  output logic       err_nxt,
  output logic       seen
);
  logic [3:0] code;
  logic       err;

  assign code_nxt = wr ? code_in : code;
  assign err_nxt  = wr ? err_in  : err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code <= '0;
      err  <= 1'b0;
      seen <= 1'b0;
    end else begin
      code <= code_nxt;
      err  <= err_nxt;
      // A capture that lands on a clear still marks the digit as seen.
      seen <= clr ? wr : (seen | wr);
    end
  end
endmodule

module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              segments,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  input  logic                    frame_ready
);
  localparam int SW = NUM_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  typedef struct packed {
    logic [3:0] code;
    logic       err;
  } dec_t;

  typedef enum logic {COLLECT, HOLD} state_t;

  function automatic dec_t decode(input logic [6:0] p);
    dec_t d;
    d = '{code: 4'hF, err: 1'b1};
    case (p)
      7'b1111110: d = '{code: 4'h0, err: 1'b0};
      7'b0110000: d = '{code: 4'h1, err: 1'b0};
      7'b1101101: d = '{code: 4'h2, err: 1'b0};
      7'b1111001: d = '{code: 4'h3, err: 1'b0};
      7'b0110011: d = '{code: 4'h4, err: 1'b0};
      7'b1011011: d = '{code: 4'h5, err: 1'b0};
      7'b1011111: d = '{code: 4'h6, err: 1'b0};
      7'b1110000: d = '{code: 4'h7, err: 1'b0};
      7'b1111111: d = '{code: 4'h8, err: 1'b0};
      7'b1110011: d = '{code: 4'h9, err: 1'b0};
      7'b1001111: d = '{code: 4'hE, err: 1'b1};
      7'b0000000: d = '{code: 4'hF, err: 1'b0};
      default:    d = '{code: 4'hF, err: 1'b1};
    endcase
    return d;
  endfunction

  logic [SW-1:0] sync1, sync2;
  logic [CW-1:0] stab_cnt;

  // The counter tracks how long sync2 has held its value, so the strobe sees the
  // settled sample directly in the cycle it fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      stab_cnt <= '0;
    end else begin
      sync1 <= {digit_sel, segments};
      sync2 <= sync1;
      if (sync1 != sync2)
        stab_cnt <= '0;
      else if (stab_cnt != CW'(STABLE_CYCLES))
        stab_cnt <= stab_cnt + CW'(1);
    end
  end

  logic [NUM_DIGITS-1:0] s_sel;
  logic [6:0]            s_seg;
  logic                  strobe, cap_ok;
  dec_t                  dec;

  assign s_sel  = sync2[SW-1:7];
  assign s_seg  = sync2[6:0];
  assign strobe = (stab_cnt == CW'(STABLE_CYCLES - 1));
  assign cap_ok = strobe && $onehot(s_sel);
  assign dec    = decode(s_seg);

  state_t state, state_nxt;
  logic   load, clr;
  logic [NUM_DIGITS-1:0][3:0] code_nxt;
  logic [NUM_DIGITS-1:0]      err_nxt;
  logic [NUM_DIGITS-1:0]      mask;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_slot
    seg7_scan_slot u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr      (cap_ok && s_sel[g]),
      .clr     (clr),
      .code_in (dec.code),
      .err_in  (dec.err),
      .code_nxt(code_nxt[g]),
      .err_nxt (err_nxt[g]),
      .seen    (mask[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  // Mask-full is judged on the registered mask; the transfer copies the next-state
  // working values so a capture on the transfer edge still makes it into the frame.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    clr       = 1'b0;
    case (state)
      COLLECT: if (&mask) begin
        state_nxt = HOLD;
        load      = 1'b1;
        clr       = 1'b1;
      end
      HOLD: if (frame_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits      <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= (state_nxt == HOLD);
      if (load) begin
        digits    <= code_nxt;
        digit_err <= err_nxt;
      end
    end
  end
endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Sequential decoder that recovers decimal digits from a multiplexed, one-hot-scanned 7-segment display bus, the inverse of the digit-to-segment encoding used on the display side. It samples the segment lines and digit-select strobes, waits for each scan slot to settle, and decodes each segment pattern back to a 4-bit code. Completed frames are handed to downstream logic over a valid/ready handshake. Used for loopback checking of the display path and for reading external 7-segment sources.

## Interface
- NUM_DIGITS, 4: number of scanned digit positions (≥1).
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before a capture (≥2).

- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- segments  in  7  segment lines, bit6=a … bit0=g, 1 = lit; asynchronous to clk.
- digit_sel  in  NUM_DIGITS  one-hot active-high scan strobe, bit i = digit i; asynchronous to clk.
- digits  out  4*NUM_DIGITS  decoded frame, digit i at [4i+3:4i].
- digit_err  out  NUM_DIGITS  per-digit flag: pattern was the error glyph or unrecognized.
- frame_valid  out  1  frame on digits/digit_err is valid.
- frame_ready  in  1  consumer accepts frame.

## Operation
- Input synchronizer: {digit_sel, segments} pass through 2 flop stages. All later logic sees only stage-2 value S.
- Stability counter (width ≥ clog2(STABLE_CYCLES+1)): cleared to 0 when S differs from previous S. Otherwise it increments, saturating at STABLE_CYCLES.
- Capture strobe: one-cycle pulse when the counter reaches STABLE_CYCLES-1, meaning S has been identical for STABLE_CYCLES cycles. Exactly one strobe per stable period.
- A strobe is discarded if digit_sel in S is all-zero or has more than one bit set.
- Decode on strobe, 7-bit pattern to code/err:
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1110011→9; all with err=0.
  - 1001111 ("E" glyph) → 4'hE, err=1.
  - 0000000 (blank) → 4'hF, err=0.
  - Any other pattern → 4'hF, err=1.
- Working registers: per digit, one 4-bit code and one err bit, plus a NUM_DIGITS-bit captured mask.
  - A valid strobe writes the selected digit's working code/err and sets its mask bit.
  - If a digit is recaptured before the frame completes, the latest value wins.
- FSM:
  - COLLECT: when the mask is all ones (evaluated after this cycle's update), transition to HOLD on the next edge. On that edge, copy working registers to digits/digit_err, clear the mask, and set frame_valid=1.
  - HOLD: frame_valid=1 and digits/digit_err are frozen. Captures continue into the working registers and mask.
  - HOLD exit: on frame_valid & frame_ready, transition to COLLECT and clear frame_valid on that edge. The mask is not cleared at this edge.
  - COLLECT re-entry: if the mask is already full on entering COLLECT, the next frame is presented one cycle later (one-cycle bubble minimum between frames).
- Simultaneous events:
  - Capture in the same cycle as the mask-full transfer: the capture's value is included in the transferred frame.
  - Capture in the same cycle as mask clear: the mask bit for that digit remains set afterwards.
- Reset (asynchronous assert, synchronous release via normal clocking), also valid mid-frame:
  - digits=0, digit_err=0, frame_valid=0.
  - Mask=0, counter=0, synchronizers=0, working registers=0, state=COLLECT.
  - No partial frame survives reset.

## Timing
- Pins held constant from sampling edge k: the digit's working register updates at edge k+STABLE_CYCLES+1.
- If that capture completes the mask, digits/frame_valid update at edge k+STABLE_CYCLES+2.
- Pin glitches shorter than STABLE_CYCLES cycles (after synchronization) produce no capture.
- frame_valid, once high, stays high with stable data until the handshake edge. No combinational path from inputs to outputs.
- Throughput: one frame per max(NUM_DIGITS scan slots, 2 cycles).

## Test plan
- Reset state: assert rst_n=0 mid-frame (2 of 4 digits captured), release → all outputs 0. The next complete frame contains only digits captured after reset.
- Basic frame (NUM_DIGITS=4, STABLE_CYCLES=4): scan digit0..3 with 0110000, 1101101, 1111001, 0110011, each held 8 cycles → frame_valid=1 with digits=16'h4321, digit_err=0. The timing from the final digit's pin change must match the Timing section.
- Error/blank decoding: patterns 1001111, 0000000, 0000001 on digits 0–2 and 1111111 on digit 3 → digits=16'h8FFE, digit_err=4'b0101.
- Glitch filter: hold a digit's pattern for 3 synchronized cycles, then change → no capture and mask unchanged. Holding the same pattern for 4 cycles → exactly one capture.
- Illegal select: digit_sel=4'b0000 or 4'b0110, held stable → no working register or mask change.
- Backpressure: frame_ready=0 for 50 cycles while scanning continues → outputs frozen at frame A. Raise frame_ready for one cycle → frame_valid drops for ≥1 cycle, then frame B (latest captured values) is presented.
